// File: rtl/hc595_scan_ctrl.sv
// hc595_scan_ctrl: scans up to eight 7-segment digits through a pair of chained 74HC595 shift registers.
module hc595_scan_ctrl #(
  parameter int CLK_DIV        = 5,
  parameter int SCAN_HOLD      = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        load,
  input  logic [31:0] disp_data,
  input  logic [7:0]  dp_en,
  input  logic [7:0]  digit_en,
  output logic        shcp,
  output logic        stcp,
  output logic        ds,
  output logic        busy,
  output logic        frame_done
);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, HOLD} state_t;
  localparam logic [7:0]  DIV_M1  = 8'(CLK_DIV - 1);
  localparam logic [19:0] HOLD_M1 = 20'(SCAN_HOLD - 1);
  localparam logic [6:0]  SEG_LUT [16] = '{
    7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
    7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
  };
  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [19:0] hold_q, hold_d;
  logic [2:0]  idx_q, idx_d, idx_nx;
  logic [15:0] frame_q, frame_d, frame_new;
  logic [31:0] disp_q, disp_d;
  logic [7:0]  dp_q, dp_d, den_q, den_d;
  logic        shcp_q, shcp_d, stcp_q, stcp_d, ds_q, ds_d, busy_q, busy_d, fd_q, fd_d;
  logic [3:0]  nib;
  logic        en;
  logic [7:0]  seg, sel;
  // Disabled or all-off digits produce a blank frame before polarity is applied.
  assign nib       = disp_q[{idx_q, 2'b00} +: 4];
  assign en        = den_q[idx_q];
  assign seg       = en ? {dp_q[idx_q], SEG_LUT[nib]} : 8'h00;
  assign sel       = en ? 8'b1 << idx_q : 8'h00;
  assign frame_new = {SEG_ACTIVE_LOW ? ~seg : seg, DIG_ACTIVE_LOW ? ~sel : sel};
  // Smallest forward distance wins; with no other enabled digit the index holds.
  always_comb begin
    idx_nx = idx_q;
    for (int k = 7; k >= 1; k--) if (den_q[idx_q + 3'(k)]) idx_nx = idx_q + 3'(k);
  end
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    ds_d    = ds_q;
    fd_d    = 1'b0;
    disp_d  = load ? disp_data : disp_q;
    dp_d    = load ? dp_en : dp_q;
    den_d   = load ? digit_en : den_q;
    case (state_q)
      IDLE: if (run) state_d = LOAD;
      LOAD: begin
        state_d = SHIFT_LO;
        ds_d    = frame_new[15];
        frame_d = {frame_new[14:0], 1'b0};
        div_d   = '0;
        bit_d   = '0;
      end
      SHIFT_LO: begin
        div_d = div_q == DIV_M1 ? '0 : div_q + 8'd1;
        if (div_q == DIV_M1) state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        div_d = div_q == DIV_M1 ? '0 : div_q + 8'd1;
        if (div_q == DIV_M1) begin
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd15) state_d = LATCH;
          else begin
            state_d = SHIFT_LO;
            ds_d    = frame_q[15];
            frame_d = {frame_q[14:0], 1'b0};
          end
        end
      end
      LATCH: begin
        div_d = div_q == DIV_M1 ? '0 : div_q + 8'd1;
        if (div_q == DIV_M1) begin
          state_d = HOLD;
          fd_d    = 1'b1;
          idx_d   = idx_nx;
          hold_d  = '0;
        end
      end
      HOLD: begin
        hold_d = hold_q == HOLD_M1 ? '0 : hold_q + 20'd1;
        if (hold_q == HOLD_M1) state_d = run ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
    shcp_d = state_d == SHIFT_HI;
    stcp_d = state_d == LATCH;
    busy_d = state_d inside {LOAD, SHIFT_LO, SHIFT_HI, LATCH};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      disp_q  <= '0;
      dp_q    <= '0;
      den_q   <= '0;
      shcp_q  <= 1'b0;
      stcp_q  <= 1'b0;
      ds_q    <= 1'b0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      disp_q  <= disp_d;
      dp_q    <= dp_d;
      den_q   <= den_d;
      shcp_q  <= shcp_d;
      stcp_q  <= stcp_d;
      ds_q    <= ds_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
    end
  end
  assign shcp       = shcp_q;
  assign stcp       = stcp_q;
  assign ds         = ds_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
endmodule
